// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matmul sequencer.
// The operand stream is A row-major followed by B row-major, 18 bytes in total.
package matmul_pkg;

    localparam int DIM       = 3;
    localparam int N_ELEM    = DIM * DIM;
    localparam int DATA_W    = 8;
    localparam int N_OPERAND = 2 * N_ELEM;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [N_ELEM-1:0] mat_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_SETTLE,
        S_DRAIN
    } state_t;

    // Maps the running operand byte count onto an element index inside A or B.
    function automatic logic [3:0] operand_slot(input logic [4:0] cnt);
        logic [4:0] slot;
        slot = (cnt < 5'(N_ELEM)) ? cnt : (cnt - 5'(N_ELEM));
        return slot[3:0];
    endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Operand stream, result stream and engine connections of the matmul sequencer.
// The slave modport is the sequencer; the master modport is its surroundings.
interface matmul_seq_if;
    import matmul_pkg::*;

    logic  i_in_valid;
    logic  o_in_ready;
    elem_t i_in_data;

    logic  o_out_valid;
    logic  i_out_ready;
    elem_t o_out_data;
    logic  o_out_last;

    logic  o_eng_trigger;
    mat_t  o_eng_a;
    mat_t  o_eng_b;
    logic  i_eng_ready;
    mat_t  i_eng_result;

    logic  o_busy;
    logic  o_err;

    modport slave (
        input  i_in_valid, i_in_data, i_out_ready, i_eng_ready, i_eng_result,
        output o_in_ready, o_out_valid, o_out_data, o_out_last,
        output o_eng_trigger, o_eng_a, o_eng_b, o_busy, o_err
    );

    modport master (
        output i_in_valid, i_in_data, i_out_ready, i_eng_ready, i_eng_result,
        input  o_in_ready, o_out_valid, o_out_data, o_out_last,
        input  o_eng_trigger, o_eng_a, o_eng_b, o_busy, o_err
    );

endinterface

// File: rtl/matmul_seq.sv
// Sequencer for an external 3x3 matmul engine: loads A and B from a byte stream,
// fires the engine, waits for completion under a watchdog, then drains C as bytes.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   S_IDLE      | ready for the first operand byte (A[0])
//   S_LOAD      | accepting operand bytes 1..17 into A then B
//   S_FIRE      | waiting for engine ready, then pulsing the trigger
//   S_WAIT_BUSY | waiting for the engine to drop ready
//   S_WAIT_DONE | waiting for the engine to raise ready again
//   S_SETTLE    | letting the result settle, capturing C on the last cycle
//   S_DRAIN     | streaming C[0..8] out, last flag on C[8]
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          i_clk,
    input logic          i_rst_n,
    matmul_seq_if.slave  bus
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LOAD   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LOAD  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       LAST_BYTE = 5'(N_OPERAND - 1);
    localparam logic [3:0]       LAST_IDX  = 4'(N_ELEM - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [SET_W-1:0] settle_q, settle_d;
    mat_t             a_q, a_d;
    mat_t             b_q, b_d;
    mat_t             c_q, c_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    elem_t            out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             trig_q, trig_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic             accept;
    logic             wd_expired;
    logic [3:0]       slot;
    logic [3:0]       idx_next;

    assign accept     = in_ready_q & bus.i_in_valid;
    assign wd_expired = (wd_q == '0);
    assign slot       = operand_slot(cnt_q);
    assign idx_next   = idx_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        settle_d    = settle_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        trig_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d[0]  = bus.i_in_data;
                    cnt_d   = 5'd1;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    if (cnt_q < 5'(N_ELEM)) begin
                        a_d[slot] = bus.i_in_data;
                    end else begin
                        b_d[slot] = bus.i_in_data;
                    end
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d   = '0;
                        wd_d    = WD_LOAD;
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            S_FIRE: begin
                if (bus.i_eng_ready) begin
                    trig_d  = 1'b1;
                    wd_d    = WD_LOAD;
                    state_d = S_WAIT_BUSY;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end

            S_WAIT_BUSY: begin
                if (!bus.i_eng_ready) begin
                    wd_d    = WD_LOAD;
                    state_d = S_WAIT_DONE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end

            S_WAIT_DONE: begin
                if (bus.i_eng_ready) begin
                    settle_d = SET_LOAD;
                    state_d  = S_SETTLE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q - WD_W'(1);
                end
            end

            S_SETTLE: begin
                if (settle_q == '0) begin
                    c_d         = bus.i_eng_result;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = bus.i_eng_result[0];
                    out_last_d  = 1'b0;
                    state_d     = S_DRAIN;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end

            S_DRAIN: begin
                if (bus.i_out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_last_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d      = idx_next;
                        out_data_d = c_q[idx_next];
                        out_last_d = (idx_next == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs follow the next state so they line up with state_q.
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wd_q        <= '0;
            settle_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            settle_q    <= settle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_in_ready    = in_ready_q;
    assign bus.o_out_valid   = out_valid_q;
    assign bus.o_out_data    = out_data_q;
    assign bus.o_out_last    = out_last_q;
    assign bus.o_eng_trigger = trig_q;
    assign bus.o_eng_a       = a_q;
    assign bus.o_eng_b       = b_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_err         = err_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq with a behavioural 3x3 engine beside it.
// Table of jobs plus hand-written reset and watchdog sequences; results go through a scoreboard queue.
module tb_matmul_seq;
    import matmul_pkg::*;

    localparam int ENG_LAT = 4;

    typedef struct packed {
        mat_t       a;
        mat_t       b;
        mat_t       c;
        logic [3:0] pat;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;
    matmul_seq_if bus();

    matmul_seq #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[5];

    logic eng_stuck;
    int   eng_cnt;
    mat_t snap_a, snap_b;
    logic inflight;
    int   trig_count = 0;
    int   hold_viol = 0;

    function automatic mat_t mm_ref(input mat_t a, input mat_t b);
        mat_t c;
        int s;
        for (int r = 0; r < 3; r++) begin
            for (int col = 0; col < 3; col++) begin
                s = 0;
                for (int k = 0; k < 3; k++) s += int'(a[r*3+k]) * int'(b[k*3+col]);
                c[r*3+col] = 8'(s);
            end
        end
        return c;
    endfunction

    // Engine: drops ready on trigger, raises it again ENG_LAT cycles later with the product.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_eng_ready  <= 1'b1;
            bus.i_eng_result <= '0;
            eng_cnt          <= 0;
            inflight         <= 1'b0;
        end else begin
            if (bus.o_eng_trigger) begin
                trig_count <= trig_count + 1;
                snap_a     <= bus.o_eng_a;
                snap_b     <= bus.o_eng_b;
                inflight   <= 1'b1;
            end else if (bus.o_out_valid || bus.o_err) begin
                inflight <= 1'b0;
            end
            if (eng_stuck) begin
                bus.i_eng_ready <= 1'b1;
            end else if (bus.o_eng_trigger && eng_cnt == 0) begin
                bus.i_eng_ready  <= 1'b0;
                bus.i_eng_result <= {N_ELEM{8'hEE}};
                eng_cnt          <= ENG_LAT;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    bus.i_eng_ready  <= 1'b1;
                    bus.i_eng_result <= mm_ref(snap_a, snap_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (inflight && (bus.o_eng_a !== snap_a || bus.o_eng_b !== snap_b)) hold_viol++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        int guard = 0;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = d;
        while (!bus.o_in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("in_ready_timeout", guard, 0);
        @(negedge clk);
        bus.i_in_valid = 1'b0;
    endtask

    task automatic send_job(input mat_t a, input mat_t b);
        for (int i = 0; i < N_ELEM; i++) send_byte(a[i]);
        for (int i = 0; i < N_ELEM; i++) send_byte(b[i]);
    endtask

    task automatic push_exp(input mat_t c);
        exp_t e;
        for (int i = 0; i < N_ELEM; i++) begin
            e.d    = c[i];
            e.last = (i == N_ELEM - 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain(input logic [3:0] pat);
        int got = 0;
        int k = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [7:0] hd = '0;
        logic hl = 1'b0;
        exp_t e;
        while (got < N_ELEM && cyc < 400) begin
            if (bus.o_out_valid) begin
                if (stalled) begin
                    chk("stall_data_hold", 32'(bus.o_out_data), 32'(hd));
                    chk("stall_last_hold", 32'(bus.o_out_last), 32'(hl));
                end
                bus.i_out_ready = pat[k % 4];
                k++;
                if (bus.i_out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_pending", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(bus.o_out_data), 32'(e.d));
                        chk("out_last", 32'(bus.o_out_last), 32'(e.last));
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = bus.o_out_data;
                    hl = bus.o_out_last;
                end
            end else begin
                bus.i_out_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.i_out_ready = 1'b0;
        if (got < N_ELEM) chk("drain_timeout", got, N_ELEM);
    endtask

    task automatic run_vec(input vec_t v);
        int t0, h0;
        t0 = trig_count;
        h0 = hold_viol;
        push_exp(v.c);
        send_job(v.a, v.b);
        drain(v.pat);
        chk("post_valid_low", 32'(bus.o_out_valid), 0);
        chk("post_busy_low", 32'(bus.o_busy), 0);
        chk("post_in_ready", 32'(bus.o_in_ready), 1);
        chk("sb_empty", sb.size(), 0);
        chk("trigger_once", trig_count - t0, 1);
        chk("operand_hold", hold_viol - h0, 0);
    endtask

    initial begin
        int n;
        int viol;
        mat_t m;

        // job table: identity x 1..9, 16s, 255s, two random jobs (one with 1,0,0,1 back-pressure)
        vecs[0].a = '0;
        vecs[0].a[0] = 8'd1; vecs[0].a[4] = 8'd1; vecs[0].a[8] = 8'd1;
        for (int i = 0; i < N_ELEM; i++) begin
            vecs[0].b[i] = 8'(i + 1);
            vecs[0].c[i] = 8'(i + 1);
        end
        vecs[0].pat = 4'b1111;
        vecs[1].a = {N_ELEM{8'd16}};  vecs[1].b = {N_ELEM{8'd16}};  vecs[1].c = '0;
        vecs[1].pat = 4'b1111;
        vecs[2].a = {N_ELEM{8'd255}}; vecs[2].b = {N_ELEM{8'd255}}; vecs[2].c = {N_ELEM{8'd3}};
        vecs[2].pat = 4'b1111;
        for (int v = 3; v < 5; v++) begin
            for (int i = 0; i < N_ELEM; i++) begin
                vecs[v].a[i] = 8'($urandom_range(0, 255));
                vecs[v].b[i] = 8'($urandom_range(0, 255));
            end
            vecs[v].c = mm_ref(vecs[v].a, vecs[v].b);
        end
        vecs[3].pat = 4'b1001;
        vecs[4].pat = 4'b0110;

        rst_n = 1'b0;
        eng_stuck = 1'b0;
        bus.i_in_valid = 1'b0;
        bus.i_in_data = '0;
        bus.i_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_out_valid", 32'(bus.o_out_valid), 0);
        chk("rst_out_last", 32'(bus.o_out_last), 0);
        chk("rst_out_data", 32'(bus.o_out_data), 0);
        chk("rst_trigger", 32'(bus.o_eng_trigger), 0);
        chk("rst_err", 32'(bus.o_err), 0);
        chk("rst_eng_a_zero", 32'(bus.o_eng_a == '0), 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.o_in_ready), 1);

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // reset after 7 operand bytes, then a full job must still be right
        for (int i = 0; i < 7; i++) send_byte(8'(i + 40));
        chk("midload_busy", 32'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midload_rst_busy", 32'(bus.o_busy), 0);
        chk("midload_rst_in_ready", 32'(bus.o_in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[3]);

        // reset while C is being presented
        send_job(vecs[4].a, vecs[4].b);
        n = 0;
        while (!bus.o_out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("middrain_valid_seen", 32'(bus.o_out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("middrain_rst_valid", 32'(bus.o_out_valid), 0);
        chk("middrain_rst_data", 32'(bus.o_out_data), 0);
        chk("middrain_rst_last", 32'(bus.o_out_last), 0);
        chk("middrain_rst_busy", 32'(bus.o_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);

        // engine never drops ready: watchdog fires 64 cycles after WAIT_BUSY entry
        eng_stuck = 1'b1;
        for (int i = 0; i < N_ELEM; i++) m[i] = 8'(i);
        send_job(m, m);
        n = 0;
        while (!bus.o_eng_trigger && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_trigger_seen", 32'(bus.o_eng_trigger), 1);
        n = 0;
        viol = 0;
        while (!bus.o_err && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.o_out_valid) viol++;
        end
        chk("timeout_latency", n, 64);
        chk("timeout_no_output", viol, 0);
        chk("timeout_busy", 32'(bus.o_busy), 0);
        chk("timeout_in_ready", 32'(bus.o_in_ready), 1);
        @(negedge clk);
        chk("err_one_cycle", 32'(bus.o_err), 0);
        chk("timeout_valid_after", 32'(bus.o_out_valid), 0);
        eng_stuck = 1'b0;
        @(negedge clk);
        run_vec(vecs[2]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles waited after engine ready re-asserts before capturing the result.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: maximum cycles waited for each engine ready transition.
REQ-003 i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_in_valid, o_in_ready, i_in_data  in/out/in  1/1/8  operand byte stream: A row-major elements 0..8, then B row-major elements 0..8.
REQ-006 o_out_valid, i_out_ready, o_out_data, o_out_last  out/in/out/out  1/1/8/1  result byte stream: C row-major elements 0..8; o_out_last marks element 8.
REQ-007 o_eng_trigger  output  1  trigger to the 3x3 matmul engine.
REQ-008 o_eng_a, o_eng_b  output  9x8  operand arrays to the engine, indexed [row*3+col].
REQ-009 i_eng_ready, i_eng_result  input  1 / 9x8  engine ready flag and result array.
REQ-010 o_busy  output  1  high in every state except IDLE.
REQ-011 o_err  output  1  one-cycle pulse on engine timeout.

Function
REQ-012 FSM states: IDLE, LOAD, FIRE, WAIT_BUSY, WAIT_DONE, SETTLE, DRAIN.
REQ-013 IDLE: o_in_ready=1; the first accepted byte (valid&ready) is written to A[0], and the FSM moves to LOAD.
REQ-014 LOAD: o_in_ready=1; a 5-bit load counter (0..17) steers each accepted byte to A[cnt] when cnt<9, else to B[cnt-9]; after byte 17 is accepted, the FSM moves to FIRE.
REQ-015 No byte is accepted outside IDLE/LOAD (o_in_ready=0 there).
REQ-016 FIRE: o_eng_trigger is asserted for exactly one cycle, only when i_eng_ready=1; if i_eng_ready=0, FIRE holds (subject to timeout); after the trigger, the FSM moves to WAIT_BUSY.
REQ-017 WAIT_BUSY: wait for i_eng_ready=0, then move to WAIT_DONE.
REQ-018 WAIT_DONE: wait for i_eng_ready=1, then move to SETTLE.
REQ-019 SETTLE: count SETTLE_CYCLES cycles; on the final cycle, capture all 9 i_eng_result entries into an internal C register, then move to DRAIN.
REQ-020 o_eng_a/o_eng_b are driven from internal registers continuously and SHALL NOT change between the trigger and the capture.
REQ-021 DRAIN: o_out_valid=1 and o_out_data=C[idx]; idx advances only on i_out_ready; o_out_data/o_out_last are held stable while stalled; o_out_last=1 when idx=8; the handshake on idx=8 returns the FSM to IDLE.
REQ-022 The first input byte may be accepted in the cycle after the last output handshake (no overlap between jobs).
REQ-023 Arithmetic is the engine's: each C element is the sum of three 8-bit products, truncated modulo 256; the sequencer passes the value unchanged.
REQ-024 Timeout: a watchdog counter is cleared on entry to FIRE, WAIT_BUSY and WAIT_DONE; if it reaches TIMEOUT_CYCLES in any of these states, the FSM goes to IDLE, o_err pulses for one cycle, and no output is produced.
REQ-025 i_in_valid while o_in_ready=0 is ignored (the byte is not consumed).

Reset
REQ-026 Asserting i_rst_n=0 at any time, including mid-LOAD or mid-DRAIN, immediately forces: state=IDLE, all counters=0, o_out_valid=0, o_out_last=0, o_eng_trigger=0, o_busy=0, o_err=0, o_out_data=0.
REQ-027 Operand and result registers reset to 0; a partially loaded job is discarded.
REQ-028 o_in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-029 A shared package matmul_pkg holds the state enum, N_ELEM=9, DIM=3, DATA_W=8, and the operand byte count 18.
REQ-030 No sub-module; the engine is instantiated by the parent, beside matmul_seq.

Verification
REQ-031 A=identity (1,0,0,0,1,0,0,0,1), B=1..9, i_out_ready=1 -> output 1..9, with o_out_last on 9.
REQ-032 A=all 16, B=all 16 -> all nine outputs 0 (768 mod 256); A=all 255, B=all 255 -> all nine outputs 3.
REQ-033 i_out_ready toggled 1,0,0,1 through DRAIN -> each byte appears exactly once, in order, with data held during stalls.
REQ-034 Engine model holding i_eng_ready=1 permanently after the trigger -> o_err pulses 64 cycles after WAIT_BUSY entry; state returns to IDLE; o_out_valid stays 0.
REQ-035 i_rst_n pulsed low after 7 input bytes -> o_busy=0 immediately; a full new 18-byte job then yields a correct result.
